// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a 2-bit counter PHT and a direct-mapped BTB, both indexed by PC[INDEX_BITS+1:2].
// It trains from EX-stage branch resolution and keeps running branch and mispredict counts.
module branch_predictor #(
    parameter int          DBITS      = 32,
    parameter int          INDEX_BITS = 6,
    parameter logic [3:0]  BRANCH_OP  = 4'b0010
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DBITS-1:0] IF_PC,
    output logic             prediction,
    output logic [DBITS-1:0] predPC,
    output logic             btbHit,
    input  logic             EX_valid,
    input  logic [3:0]       EX_opcode,
    input  logic [DBITS-1:0] EX_PC,
    input  logic [DBITS-1:0] EX_PC_IMM,
    input  logic             EX_condFlag,
    input  logic             EX_prediction,
    output logic [31:0]      branchCount,
    output logic [31:0]      mispredCount
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = DBITS - INDEX_BITS - 2;

    logic [1:0]          pht_reg       [ENTRIES];
    logic                btb_valid_reg [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_reg   [ENTRIES];
    logic [DBITS-1:0]    btb_target_reg[ENTRIES];
    logic [31:0]         branch_count_reg;
    logic [31:0]         mispred_count_reg;

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;
    logic                  upd;
    logic                  unused_pc_bits;

    assign if_idx = IF_PC[INDEX_BITS+1:2];
    assign if_tag = IF_PC[DBITS-1:INDEX_BITS+2];
    assign ex_idx = EX_PC[INDEX_BITS+1:2];
    assign ex_tag = EX_PC[DBITS-1:INDEX_BITS+2];
    assign upd    = EX_valid && (EX_opcode == BRANCH_OP);
    assign unused_pc_bits = ^{IF_PC[1:0], EX_PC[1:0]};

    // Lookup sees only registered table state, so a same-cycle update is not bypassed.
    assign btbHit     = reset_n && btb_valid_reg[if_idx] && (btb_tag_reg[if_idx] == if_tag);
    assign prediction = btbHit && pht_reg[if_idx][1];
    assign predPC     = prediction ? btb_target_reg[if_idx] : IF_PC + DBITS'(4);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic wr_en;
            assign wr_en = upd && (ex_idx == INDEX_BITS'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pht_reg[gi]        <= 2'b01;
                    btb_valid_reg[gi]  <= 1'b0;
                    btb_tag_reg[gi]    <= '0;
                    btb_target_reg[gi] <= '0;
                end else if (wr_en) begin
                    if (EX_condFlag) begin
                        if (pht_reg[gi] != 2'b11)
                            pht_reg[gi] <= pht_reg[gi] + 2'b01;
                        // Taken branches claim the entry even if another tag aliases here.
                        btb_valid_reg[gi]  <= 1'b1;
                        btb_tag_reg[gi]    <= ex_tag;
                        btb_target_reg[gi] <= EX_PC_IMM;
                    end else if (pht_reg[gi] != 2'b00) begin
                        pht_reg[gi] <= pht_reg[gi] - 2'b01;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count_reg  <= '0;
            mispred_count_reg <= '0;
        end else if (upd) begin
            branch_count_reg <= branch_count_reg + 32'd1;
            if (EX_prediction != EX_condFlag)
                mispred_count_reg <= mispred_count_reg + 32'd1;
        end
    end

    assign branchCount  = branch_count_reg;
    assign mispredCount = mispred_count_reg;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the EX-stage branch resolution logic. Produces the `prediction` bit and predicted next PC at IF.
- Consumes EX-stage resolution (actual outcome, target, the prediction that was made) to train its tables.
- Contents: 2-bit saturating-counter pattern history table (PHT), direct-mapped branch target buffer (BTB), mispredict statistics counters.

Parameters:
- DBITS, 32, PC/data width.
- INDEX_BITS, 6, log2 of PHT/BTB entries (64 entries).
- BRANCH_OP, 4'b0010, EX opcode value identifying a conditional branch.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- IF_PC  input  DBITS  PC of instruction in fetch.
- prediction  output  1  1 = predict taken.
- predPC  output  DBITS  predicted next PC.
- btbHit  output  1  BTB valid and tag match for IF_PC.
- EX_valid  input  1  EX stage holds a valid instruction.
- EX_opcode  input  4  EX instruction opcode.
- EX_PC  input  DBITS  PC of EX instruction.
- EX_PC_IMM  input  DBITS  resolved branch target.
- EX_condFlag  input  1  actual outcome, 1 = taken.
- EX_prediction  input  1  prediction carried down the pipe with this branch.
- branchCount  output  32  resolved branches since reset.
- mispredCount  output  32  mispredicted branches since reset.

Behaviour:
- Index = PC[INDEX_BITS+1:2]. Tag = PC[DBITS-1:INDEX_BITS+2].
- PHT entry: 2 bits. 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- BTB entry: valid, tag, DBITS target.
- Lookup is combinational from IF_PC against current table state:
  - btbHit = valid[idx] & (tag[idx] == IF_PC tag).
  - prediction = btbHit & PHT[idx][1].
  - predPC = BTB target if prediction, else IF_PC + 4 (modulo 2^DBITS).
- Update strobe upd = EX_valid & (EX_opcode == BRANCH_OP). Non-branch or invalid EX: no table or counter change.
- On rising clk with upd, at index/tag of EX_PC:
  - PHT: taken increments, saturating at 11; not-taken decrements, saturating at 00.
  - BTB, taken: write valid=1, tag, target=EX_PC_IMM. This overwrites any aliasing entry.
  - BTB, not-taken: left unchanged.
  - branchCount increments, wrapping at 2^32.
  - mispredCount increments (wrapping) when EX_prediction != EX_condFlag.
- Simultaneous IF lookup and EX update to the same index: lookup returns pre-update state that cycle; new state is visible the following cycle. No bypass.
- Single write port; exactly one update per cycle maximum.
- Reset (async assert, deassert synchronous to clk):
  - All PHT entries = 01. All BTB valid = 0, tags and targets = 0.
  - branchCount = mispredCount = 0.
  - Outputs during reset: prediction=0, btbHit=0, predPC=IF_PC+4.
- Reset asserted mid-update: update is discarded; tables show the reset state immediately.
- Latency: prediction 0 cycles (combinational); training effective 1 cycle after the update edge.

Test Plan:
- Reset, IF_PC=0x4 -> prediction=0, btbHit=0, predPC=0x8, both counts=0.
- One update: EX_PC=0x4, EX_PC_IMM=0x20, condFlag=1, EX_prediction=0 -> next cycle with IF_PC=0x4: prediction=1, btbHit=1, predPC=0x20, branchCount=1, mispredCount=1.
- Two further not-taken updates at 0x4 (EX_prediction=1, then 0) -> PHT 10->01->00; prediction=0, btbHit=1, predPC=0x8; branchCount=3, mispredCount=2.
- Aliasing: after training 0x4 taken, IF_PC=0x104 (same index, different tag) -> btbHit=0, prediction=0, predPC=0x108. A taken update at 0x104 with target 0x40 makes 0x4 miss.
- Same-cycle conflict: IF_PC=0x4 while a taken update to 0x4 lands on a fresh table -> prediction=0 that cycle, 1 the next. EX_opcode=4'b1100 with EX_valid=1 -> no table or count change.
- Assert reset_n=0 between clock edges after training -> prediction drops to 0 immediately, counts=0; after release, IF_PC=0x4 -> btbHit=0.
